// File: rtl/ejem1_led_ctrl.sv
// ejem1_led_ctrl: 8-LED pattern generator (static / accumulate / rotate / bounce) paced by a prescaled tick.
// Define KEY_SYNC_EN to pass KEY through a 2-flop synchronizer before mode decode.
module ejem1_led_ctrl #(
  parameter int unsigned PRESCALE = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] SW,
  input  logic [1:0] KEY,
  output logic [7:0] LED
);

  localparam logic [1:0] MODE_STATIC = 2'd0;
  localparam logic [1:0] MODE_ACCUM  = 2'd1;
  localparam logic [1:0] MODE_ROTATE = 2'd2;
  localparam logic [1:0] MODE_BOUNCE = 2'd3;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  localparam logic [15:0] CNT_LAST = 16'(PRESCALE - 1);

  logic [1:0] key_m;

`ifdef KEY_SYNC_EN
  logic [1:0] sync1_q;
  logic [1:0] sync2_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= KEY;
      sync2_q <= sync1_q;
    end
  end

  assign key_m = sync2_q;
`else
  assign key_m = KEY;
`endif

  logic [1:0]  mode_q;
  logic [15:0] cnt_q, cnt_d;
  logic [7:0]  pat_q, pat_d;
  logic        dir_q, dir_d;
  logic        entry;
  logic        tick;
  logic [7:0]  sw_dup;
  logic [7:0]  pat_shl;
  logic [7:0]  pat_shr;
  logic        pat_onehot;

  // A mode change restarts the prescaler and swallows any tick due that cycle.
  assign entry      = (key_m != mode_q);
  assign tick       = !entry && (cnt_q == CNT_LAST);
  assign sw_dup     = {SW, SW};
  assign pat_shl    = {pat_q[6:0], 1'b0};
  assign pat_shr    = {1'b0, pat_q[7:1]};
  assign pat_onehot = (pat_q != '0) && ((pat_q & (pat_q - 8'd1)) == '0);

  always_comb begin
    cnt_d = cnt_q + 16'd1;
    if (entry || tick) begin
      cnt_d = '0;
    end
  end

  always_comb begin
    pat_d = pat_q;
    dir_d = dir_q;
    case (key_m)
      MODE_STATIC: begin
        pat_d = sw_dup;
      end
      MODE_ACCUM: begin
        if (entry) begin
          pat_d = '0;
        end else if (tick) begin
          pat_d = pat_q + {4'h0, SW};
        end
      end
      MODE_ROTATE: begin
        if (entry) begin
          pat_d = (SW == '0) ? 8'h01 : sw_dup;
        end else if (tick) begin
          pat_d = {pat_q[6:0], pat_q[7]};
        end
      end
      MODE_BOUNCE: begin
        if (entry) begin
          pat_d = 8'h01;
          dir_d = DIR_UP;
        end else if (tick) begin
          // Direction flips on arrival at an end, so the end value shows for one full tick.
          if (!pat_onehot) begin
            pat_d = 8'h01;
            dir_d = DIR_UP;
          end else if (dir_q == DIR_UP) begin
            pat_d = pat_shl;
            if (pat_shl == 8'h80) begin
              dir_d = DIR_DOWN;
            end
          end else begin
            pat_d = pat_shr;
            if (pat_shr == 8'h01) begin
              dir_d = DIR_UP;
            end
          end
        end
      end
      default: begin
        pat_d = pat_q;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mode_q <= '0;
      cnt_q  <= '0;
      pat_q  <= '0;
      dir_q  <= DIR_UP;
      LED    <= '0;
    end else begin
      mode_q <= key_m;
      cnt_q  <= cnt_d;
      pat_q  <= pat_d;
      dir_q  <= dir_d;
      LED    <= pat_q;
    end
  end

endmodule

// File: tb/tb_ejem1_led_ctrl.sv
// Scoreboard bench for ejem1_led_ctrl: expected LED values are queued with the cycle they are due.
// Works with or without KEY_SYNC_EN (key latency adjusted below).
module tb_ejem1_led_ctrl;

  localparam int unsigned P = 4;
`ifdef KEY_SYNC_EN
  localparam int unsigned KL = 2;
`else
  localparam int unsigned KL = 0;
`endif

  logic       clk;
  logic       reset;
  logic [3:0] SW;
  logic [1:0] KEY;
  logic [7:0] LED;

  ejem1_led_ctrl #(.PRESCALE(P)) dut (
    .clk   (clk),
    .reset (reset),
    .SW    (SW),
    .KEY   (KEY),
    .LED   (LED)
  );

  typedef struct {
    int unsigned due;
    logic [7:0]  val;
    string       tag;
  } exp_t;

  exp_t        sb[$];
  int unsigned cyc    = 0;
  int unsigned n_vec  = 0;
  int unsigned n_miss = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: LED=%h expected %h at cycle %0d", tag, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      exp_t e;
      e = sb.pop_front();
      check(e.tag, LED, e.val);
    end
  end

  task automatic push(input int unsigned due, input logic [7:0] v, input string tag);
    exp_t e;
    e.due = due;
    e.val = v;
    e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic wait_neg(input int unsigned t);
    while (cyc < t) @(negedge clk);
  endtask

  // Expected pattern i ticks after entry, derived from the mode's arithmetic meaning.
  function automatic logic [7:0] exp_val(input int unsigned kind, input logic [3:0] sw,
                                         input int unsigned i);
    int unsigned prod;
    int unsigned p;
    logic [7:0]  b;
    logic [15:0] t;
    exp_val = 8'h00;
    case (kind)
      1: begin
        prod    = i * 32'(sw);
        exp_val = 8'(prod);
      end
      2: begin
        b       = (sw == 4'h0) ? 8'h01 : {sw, sw};
        t       = {b, b} << (i % 8);
        exp_val = t[15:8];
      end
      3: begin
        p       = i % 14;
        exp_val = (p <= 7) ? 8'(1 << p) : 8'(1 << (14 - p));
      end
      default: exp_val = 8'h00;
    endcase
  endfunction

  task automatic start_run(input logic [1:0] key, input logic [3:0] sw, input int unsigned kind,
                           input int unsigned n, input string tag, output int unsigned endc);
    int unsigned e;
    KEY = key;
    SW  = sw;
    e   = cyc + 1 + KL;
    for (int unsigned i = 0; i < n; i++) begin
      for (int unsigned o = 0; o < P; o++) begin
        push(e + 1 + P * i + o, exp_val(kind, sw, i), tag);
      end
    end
    endc = e + P * n;
  endtask

  task automatic back_to_static();
    KEY = 2'd0;
    wait_neg(cyc + KL + 4);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned endc;
    int unsigned c;

    reset = 1'b1;
    KEY   = 2'd0;
    SW    = 4'hA;
    push(1, 8'h00, "rst");
    push(2, 8'h00, "rst");
    push(3, 8'h00, "rst_release");
    for (int unsigned d = 4; d <= 8; d++) push(d, 8'hAA, "static_aa");
    wait_neg(2);
    reset = 1'b0;

    wait_neg(7);
    SW = 4'h3;
    for (int unsigned d = 9; d <= 12; d++) push(d, 8'h33, "static_33");
    wait_neg(12);

    start_run(2'd1, 4'hA, 1, 6, "accum_a", endc);
    wait_neg(endc);
    back_to_static();

    start_run(2'd1, 4'hF, 1, 20, "accum_f_wrap", endc);
    wait_neg(endc);
    back_to_static();

    start_run(2'd1, 4'h0, 1, 3, "accum_zero", endc);
    wait_neg(endc);
    back_to_static();

    start_run(2'd2, 4'h1, 2, 10, "rotate_11", endc);
    wait_neg(endc - 5 * P);
    SW = 4'h7;
    wait_neg(endc);
    back_to_static();

    start_run(2'd2, 4'h0, 2, 9, "rotate_01", endc);
    wait_neg(endc);
    back_to_static();

    start_run(2'd3, 4'h6, 3, 30, "bounce", endc);
    wait_neg(endc);
    back_to_static();

    // Free-running KEY: posedges see 1,3,1,3,... so every cycle is an entry.
    c   = cyc;
    SW  = 4'h5;
    KEY = 2'd1;
    for (int unsigned j = 0; j < 20; j++) begin
      push(c + 2 + KL + j, (j % 2 == 1) ? 8'h01 : 8'h00, "rapid_key");
    end
    for (int j = 0; j < 20; j++) begin
      @(posedge clk);
      #2 KEY = KEY + 2'd1;
      @(negedge clk);
      #2 KEY = KEY + 2'd1;
    end
    back_to_static();
    wait_neg(cyc + 2);

    start_run(2'd3, 4'h0, 3, 5, "bounce_pre_rst", endc);
    wait_neg(endc);
    reset = 1'b1;
    push(endc + 1, 8'h00, "mid_anim_rst");
    push(endc + 2, 8'h00, "mid_anim_rst");
    wait_neg(endc + 1);
    reset = 1'b0;
    KEY   = 2'd0;
    wait_neg(endc + 4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
